hci_tcdm_bank_adapter: RTL and testbench
========================================

HCI_TCDM_BANK_ADAPTER -- requirements
Module: hci_tcdm_bank_adapter

Interface
REQ-001 SHALL have parameter AW, default 32: bank word-address width.
REQ-002 SHALL have parameter DW, default 32: data width, including any user bits.
REQ-003 SHALL have parameter BW, default 8: byte width; the byte-enable width is DW/BW.
REQ-004 SHALL have parameter IW, default 20: request ID width.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 clk_i  in  1  clock; all state updates on its rising edge.
REQ-007 rst_ni  in  1  asynchronous, active-low reset.
REQ-008 req_i  in  1  request from the interconnect bank port.
REQ-009 add_i  in  AW  bank word address.
REQ-010 wen_i  in  1  1 = read, 0 = write.
REQ-011 wdata_i  in  DW  write data.
REQ-012 be_i  in  DW/BW  byte enables.
REQ-013 id_i  in  IW  initiator ID.
REQ-014 ts_set_i  in  1  test-and-set qualifier.
REQ-015 gnt_o  out  1  grant.
REQ-016 r_valid_o  out  1  response valid.
REQ-017 r_rdata_o  out  DW  response data.
REQ-018 r_id_o  out  IW  response ID.
REQ-019 sram_req_o  out  1  SRAM chip enable.
REQ-020 sram_we_o  out  1  SRAM write enable, active high.
REQ-021 sram_addr_o  out  AW  SRAM address.
REQ-022 sram_wdata_o  out  DW  SRAM write data.
REQ-023 sram_be_o  out  DW/BW  SRAM byte enables.
REQ-024 sram_rdata_i  in  DW  SRAM read data, valid the cycle after a read.

Function
REQ-025 SHALL implement a two-state FSM with states IDLE and TS_WR.
- IDLE: gnt_o = 1.
- TS_WR: gnt_o = 0.
REQ-026 In IDLE, the request SHALL be accepted when req_i & gnt_o; the SRAM port is driven combinationally from the request:
- sram_req_o = req_i;
- sram_we_o = ~wen_i;
- sram_addr_o = add_i;
- sram_wdata_o = wdata_i;
- sram_be_o = be_i.
REQ-027 An accepted read with ts_set_i = 1 SHALL move the FSM to TS_WR and latch add_i.
- In TS_WR the SRAM port is driven as: sram_req_o = 1, sram_we_o = 1, sram_addr_o = latched address, sram_wdata_o = all-ones, sram_be_o = all-ones.
- The FSM returns to IDLE unconditionally after one cycle.
REQ-028 ts_set_i on a write (wen_i = 0) SHALL be ignored; the access is a plain write.
REQ-029 Every accepted request SHALL produce exactly one response: r_valid_o = 1 for one cycle, exactly one cycle after acceptance.
REQ-030 Read response data SHALL be r_rdata_o = sram_rdata_i; for a test-and-set this is the pre-set (old) value.
REQ-031 Write response data SHALL be r_rdata_o = 0.
REQ-032 r_id_o SHALL be registered from id_i on acceptance and hold its value until the next acceptance.
REQ-033 When r_valid_o = 0, r_rdata_o SHALL be 0.
REQ-034 In TS_WR, req_i SHALL be ignored (not granted, not forwarded); the initiator keeps it asserted per the handshake.
REQ-035 Back-to-back accepted requests SHALL sustain throughput of one per cycle; r_valid_o stays high continuously.
REQ-036 Throughput SHALL drop to one per two cycles only across a test-and-set.
REQ-037 With req_i = 0 in IDLE, sram_req_o SHALL be 0 and no response is generated.
REQ-038 The block SHALL have no combinational path from sram_rdata_i to any output except r_rdata_o.

Reset
REQ-039 While rst_ni = 0, the block SHALL force:
- FSM = IDLE;
- r_valid_o = 0;
- r_id_o = 0;
- the internal read/write flag = 0;
- the latched address = 0.
REQ-040 A reset asserted while in TS_WR SHALL abort the pending all-ones write (sram_req_o = 0 during reset) and SHALL suppress any pending response.
REQ-041 After reset release, the first request SHALL be granted in the same cycle.

Verification
REQ-042 Write then read: write add=0x10, wdata=0xCAFEBABE, be=0xF, id=3, then read add=0x10, id=5 -> r_valid one cycle after each request; read r_rdata=0xCAFEBABE with r_id=5; write r_rdata=0 with r_id=3.
REQ-043 Test-and-set: preload 0x00000007 at add=0x20, then read with ts_set=1, id=9 -> r_rdata=0x00000007, r_id=9; gnt=0 the next cycle; SRAM write of 0xFFFFFFFF at 0x20; a following read returns 0xFFFFFFFF.
REQ-044 Streaming: 8 consecutive reads on addresses 0..7 -> gnt stays high; r_valid high for 8 consecutive cycles; data and IDs returned in order.
REQ-045 Ignored qualifier: write with ts_set=1, wdata=0x12345678, be=0x3 -> plain partial write; FSM stays IDLE; a readback shows only the low two bytes updated.
REQ-046 Reset in TS_WR: assert rst_ni=0 in the TS_WR cycle -> no SRAM write occurs and no r_valid; after release gnt=1 and the location keeps its old value.

Source files
------------

// File: rtl/hci_tcdm_bank_adapter.sv
`default_nettype none
// ============================================================================
// Module   : hci_tcdm_bank_adapter
// Brief    : Adapts an HCI/TCDM bank port to a single-port SRAM macro.
//            Plain reads/writes pass through combinationally. A read that
//            carries ts_set_i returns the old word and then writes all-ones
//            to the same address in the next cycle (test-and-set).
// Revision : 1.0 - initial release
// ============================================================================
module hci_tcdm_bank_adapter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned IW = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Interconnect bank port
  input  logic             req_i,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [IW-1:0]    id_i,
  input  logic             ts_set_i,
  output logic             gnt_o,
  output logic             r_valid_o,
  output logic [DW-1:0]    r_rdata_o,
  output logic [IW-1:0]    r_id_o,
  // SRAM port
  output logic             sram_req_o,
  output logic             sram_we_o,
  output logic [AW-1:0]    sram_addr_o,
  output logic [DW-1:0]    sram_wdata_o,
  output logic [DW/BW-1:0] sram_be_o,
  input  logic [DW-1:0]    sram_rdata_i
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TS_WR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          req_accept;
  logic          r_valid_q;
  logic          rd_q;
  logic [IW-1:0] r_id_q;
  logic [AW-1:0] ts_addr_q;

  assign req_accept = req_i & gnt_o;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a test-and-set read inserts exactly one all-ones write cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i && wen_i && ts_set_i) state_d = TS_WR;
      TS_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant and SRAM port, either pass-through or the set write.
  // The chip enable is gated by reset so an interrupted set write never lands.
  always_comb begin
    gnt_o        = 1'b1;
    sram_req_o   = req_i & rst_ni;
    sram_we_o    = ~wen_i;
    sram_addr_o  = add_i;
    sram_wdata_o = wdata_i;
    sram_be_o    = be_i;
    if (state_q == TS_WR) begin
      gnt_o        = 1'b0;
      sram_req_o   = rst_ni;
      sram_we_o    = 1'b1;
      sram_addr_o  = ts_addr_q;
      sram_wdata_o = '1;
      sram_be_o    = '1;
    end
  end

  // Response tracking: one valid per accepted request, one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      rd_q      <= 1'b0;
      r_id_q    <= '0;
      ts_addr_q <= '0;
    end else begin
      r_valid_q <= req_accept;
      if (req_accept) begin
        rd_q   <= wen_i;
        r_id_q <= id_i;
        if (wen_i && ts_set_i) begin
          ts_addr_q <= add_i;
        end
      end
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_id_o    = r_id_q;
  // Write responses and idle cycles return zero; reads return the SRAM word
  assign r_rdata_o = (r_valid_q && rd_q) ? sram_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_hci_tcdm_bank_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hci_tcdm_bank_adapter
// Brief    : Self-checking bench: directed scenarios plus random traffic,
//            compared against a transaction-level memory/response model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_tcdm_bank_adapter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int IW = 20;
  localparam int BEW = DW / BW;
  localparam int MEMW = 64;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           req_i, wen_i, ts_set_i;
  logic [AW-1:0]  add_i;
  logic [DW-1:0]  wdata_i;
  logic [BEW-1:0] be_i;
  logic [IW-1:0]  id_i;
  logic           gnt_o, r_valid_o;
  logic [DW-1:0]  r_rdata_o;
  logic [IW-1:0]  r_id_o;
  logic           sram_req_o, sram_we_o;
  logic [AW-1:0]  sram_addr_o;
  logic [DW-1:0]  sram_wdata_o;
  logic [BEW-1:0] sram_be_o;
  logic [DW-1:0]  sram_rdata_i;

  hci_tcdm_bank_adapter #(.AW(AW), .DW(DW), .BW(BW), .IW(IW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .id_i(id_i), .ts_set_i(ts_set_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_id_o(r_id_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // SRAM macro behaviour (environment, not the reference)
  logic [DW-1:0] sram_mem [MEMW];
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int k = 0; k < BEW; k++)
          if (sram_be_o[k]) sram_mem[sram_addr_o[5:0]][8*k +: 8] <= sram_wdata_o[8*k +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o[5:0]];
      end
    end
  end

  // Reference model state: expected memory contents and expected response
  logic [DW-1:0] ref_mem [MEMW];
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [IW-1:0] exp_id;
  logic          busy;      // a set write is owed in the coming cycle
  logic [AW-1:0] ts_addr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: check last cycle's response, drive a request, check the
  // SRAM port and advance the model.
  task automatic bus_cycle(input logic rq, input logic rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [BEW-1:0] b,
                           input logic [IW-1:0] id, input logic ts);
    @(negedge clk_i);
    chk("r_valid", {63'd0, r_valid_o}, {63'd0, exp_valid});
    chk("r_rdata", {32'd0, r_rdata_o}, {32'd0, exp_data});
    chk("r_id", {44'd0, r_id_o}, {44'd0, exp_id});
    chk("gnt", {63'd0, gnt_o}, {63'd0, ~busy});
    req_i = rq; wen_i = rd; add_i = a; wdata_i = wd; be_i = b; id_i = id; ts_set_i = ts;
    #1;
    if (busy) begin
      chk("ts_req", {63'd0, sram_req_o}, 64'd1);
      chk("ts_we", {63'd0, sram_we_o}, 64'd1);
      chk("ts_addr", {32'd0, sram_addr_o}, {32'd0, ts_addr});
      chk("ts_wdata", {32'd0, sram_wdata_o}, {32'd0, {DW{1'b1}}});
      chk("ts_be", {60'd0, sram_be_o}, {60'd0, {BEW{1'b1}}});
      ref_mem[ts_addr[5:0]] = '1;
      busy      = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
    end else begin
      chk("sram_req", {63'd0, sram_req_o}, {63'd0, rq});
      exp_valid = rq;
      exp_data  = '0;
      if (rq) begin
        chk("sram_we", {63'd0, sram_we_o}, {63'd0, ~rd});
        chk("sram_addr", {32'd0, sram_addr_o}, {32'd0, a});
        exp_id = id;
        if (rd) begin
          exp_data = ref_mem[a[5:0]];
          if (ts) begin
            busy    = 1'b1;
            ts_addr = a;
          end
        end else begin
          chk("sram_wdata", {32'd0, sram_wdata_o}, {32'd0, wd});
          chk("sram_be", {60'd0, sram_be_o}, {60'd0, b});
          for (int k = 0; k < BEW; k++)
            if (b[k]) ref_mem[a[5:0]][8*k +: 8] = wd[8*k +: 8];
        end
      end
    end
  endtask

  task automatic idle_cycle();
    bus_cycle(1'b0, 1'b1, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MEMW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_rdata_i = '0;
    rst_ni = 1'b0;
    req_i = 1'b0; wen_i = 1'b1; add_i = '0; wdata_i = '0; be_i = '0; id_i = '0; ts_set_i = 1'b0;
    exp_valid = 1'b0; exp_data = '0; exp_id = '0; busy = 1'b0; ts_addr = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", {63'd0, gnt_o}, 64'd1);
    chk("rst_valid", {63'd0, r_valid_o}, 64'd0);
    chk("rst_id", {44'd0, r_id_o}, 64'd0);
    chk("rst_sram_req", {63'd0, sram_req_o}, 64'd0);
    rst_ni = 1'b1;

    // Write then read back
    bus_cycle(1'b1, 1'b0, 32'h10, 32'hCAFEBABE, 4'hF, 20'd3, 1'b0);
    bus_cycle(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 20'd5, 1'b0);
    idle_cycle();
    chk("wr_rd_data", {32'd0, ref_mem[16]}, 64'hCAFEBABE);

    // Test-and-set returns the old value, then the word reads all-ones
    bus_cycle(1'b1, 1'b0, 32'h20, 32'h7, 4'hF, 20'd1, 1'b0);
    bus_cycle(1'b1, 1'b1, 32'h20, 32'h0, 4'hF, 20'd9, 1'b1);
    bus_cycle(1'b1, 1'b1, 32'h20, 32'h0, 4'hF, 20'd10, 1'b0); // held during TS_WR
    bus_cycle(1'b1, 1'b1, 32'h20, 32'h0, 4'hF, 20'd10, 1'b0);
    idle_cycle();

    // Streaming reads 0..7
    for (int i = 0; i < 8; i++)
      bus_cycle(1'b1, 1'b1, i, 32'h0, 4'hF, 20'(100 + i), 1'b0);
    idle_cycle();

    // ts_set on a write is a plain partial write
    bus_cycle(1'b1, 1'b0, 32'h30, 32'hAABBCCDD, 4'hF, 20'd2, 1'b0);
    bus_cycle(1'b1, 1'b0, 32'h30, 32'h12345678, 4'h3, 20'd4, 1'b1);
    bus_cycle(1'b1, 1'b1, 32'h30, 32'h0, 4'hF, 20'd6, 1'b0);
    idle_cycle();
    chk("partial_wr", {32'd0, ref_mem[48]}, 64'hAABB5678);

    // Reset during TS_WR aborts the set write and the response
    bus_cycle(1'b1, 1'b0, 32'h28, 32'h55, 4'hF, 20'd7, 1'b0);
    bus_cycle(1'b1, 1'b1, 32'h28, 32'h0, 4'hF, 20'd8, 1'b1);
    @(negedge clk_i);
    chk("ts_rsp_valid", {63'd0, r_valid_o}, 64'd1);
    chk("ts_rsp_data", {32'd0, r_rdata_o}, 64'h55);
    rst_ni = 1'b0;
    #1;
    chk("abort_sram_req", {63'd0, sram_req_o}, 64'd0);
    chk("abort_valid", {63'd0, r_valid_o}, 64'd0);
    chk("abort_id", {44'd0, r_id_o}, 64'd0);
    @(negedge clk_i);
    chk("abort_valid2", {63'd0, r_valid_o}, 64'd0);
    rst_ni = 1'b1;
    req_i = 1'b0;
    busy = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_id = '0;
    bus_cycle(1'b1, 1'b1, 32'h28, 32'h0, 4'hF, 20'd11, 1'b0);
    idle_cycle();
    chk("abort_kept", {32'd0, sram_mem[40]}, 64'h55);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, 7)),
                $urandom, BEW'($urandom), IW'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    idle_cycle();
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
